// File: rtl/range_counter_pkg.sv
// Shared types for the range counter: counting mode, controller state and
// the depth of the reset-release synchroniser.
package range_counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RST_SYNC_STAGES = 2;

  // The unused encoding 3 behaves exactly like WRAP.
  function automatic mode_t decode_mode(input mode_t m);
    case (m)
      SAT:     return SAT;
      ONESHOT: return ONESHOT;
      default: return WRAP;
    endcase
  endfunction

endpackage

// File: rtl/range_counter_next.sv
// Combinational next-count logic: one extra bit of headroom so that running
// past a bound is detected as a terminal event instead of a modular wrap.
module range_counter_next
  import range_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic                  up,
  input  mode_t                 mode,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] lower_bound,
  input  logic [DATA_WIDTH-1:0] upper_bound,
  output logic [DATA_WIDTH-1:0] next_val,
  output logic                  ovf,
  output logic                  oor
);

  logic [DATA_WIDTH:0] step_ext;
  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic                raw_ovf;

  always_comb begin
    step_ext = {1'b0, step};
    if (step == '0) step_ext = {{DATA_WIDTH{1'b0}}, 1'b1};

    sum  = {1'b0, cur} + step_ext;
    diff = {1'b0, cur} - step_ext;

    oor = (cur < lower_bound) || (cur > upper_bound);

    // A borrow into the top bit of diff means we went below zero.
    if (up) raw_ovf = (sum > {1'b0, upper_bound});
    else    raw_ovf = diff[DATA_WIDTH] || (diff[DATA_WIDTH-1:0] < lower_bound);

    ovf = raw_ovf && !oor;

    if (oor) begin
      next_val = up ? lower_bound : upper_bound;
    end else if (ovf) begin
      if (mode == WRAP) next_val = up ? lower_bound : upper_bound;
      else              next_val = up ? upper_bound : lower_bound;
    end else begin
      next_val = up ? sum[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/range_counter.sv
// Bounded up/down counter with wrap, saturate and one-shot modes, terminal
// count pulse, saturating wrap counter and synchronised reset release.
module range_counter
  import range_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WRAP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  mode_t                 mode,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] lower_bound,
  input  logic [DATA_WIDTH-1:0] upper_bound,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  tc,
  output logic [WRAP_W-1:0]     wrap_cnt,
  output logic                  done,
  output logic                  bound_err
);

  function automatic logic [DATA_WIDTH-1:0] clamp_val(
    input logic [DATA_WIDTH-1:0] v,
    input logic [DATA_WIDTH-1:0] lo,
    input logic [DATA_WIDTH-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  logic [RST_SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic                       rst_n;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  tc_q, tc_d;
  logic [WRAP_W-1:0]     wrap_q, wrap_d;

  mode_t                 mode_dec;
  logic [DATA_WIDTH-1:0] next_val;
  logic [DATA_WIDTH-1:0] target;
  logic                  ovf;
  logic                  oor;

  // Assertion is immediate; release ripples through the synchroniser.
  always_comb rst_sync_d = {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_n     = rst_sync_q[RST_SYNC_STAGES-1];
  assign mode_dec  = decode_mode(mode);
  assign bound_err = (lower_bound > upper_bound);
  assign target    = up ? upper_bound : lower_bound;

  range_counter_next #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_next (
    .cur         (out_q),
    .up          (up),
    .mode        (mode_dec),
    .step        (step),
    .lower_bound (lower_bound),
    .upper_bound (upper_bound),
    .next_val    (next_val),
    .ovf         (ovf),
    .oor         (oor)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tc_d    = 1'b0;
    wrap_d  = wrap_q;

    case (state_q)
      INIT: begin
        out_d   = up ? lower_bound : upper_bound;
        state_d = RUN;
      end
      default: begin
        if (bound_err) begin
          // Inconsistent bounds: freeze everything until they are fixed.
          state_d = state_q;
        end else if (load) begin
          out_d   = clamp_val(load_value, lower_bound, upper_bound);
          state_d = RUN;
        end else if (en && (state_q == RUN)) begin
          out_d = next_val;
          case (mode_dec)
            SAT: begin
              tc_d = !oor && (next_val == target) && (out_q != target);
            end
            ONESHOT: begin
              if (ovf) begin
                tc_d    = 1'b1;
                state_d = DONE;
              end
            end
            default: begin
              if (ovf || oor) begin
                tc_d   = 1'b1;
                wrap_d = (&wrap_q) ? wrap_q : wrap_q + 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      out_q   <= '0;
      tc_q    <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out      = out_q;
  assign tc       = tc_q;
  assign wrap_cnt = wrap_q;
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_range_counter.sv
// Directed bench for range_counter with a cycle-level reference model and
// per-cycle output comparison plus hand-computed checkpoints.
module tb_range_counter;
  import range_counter_pkg::*;

  localparam int    W    = 32;
  localparam int    WW   = 8;
  localparam longint WMAX = (64'd1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, up, load;
  mode_t         mode;
  logic [W-1:0]  step, lower_bound, upper_bound, load_value;
  logic [W-1:0]  out;
  logic          tc, done, bound_err;
  logic [WW-1:0] wrap_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  longint m_out  = 0;
  bit     m_tc   = 0;
  longint m_wrap = 0;
  bit     m_done = 0;
  bit     m_init = 1;
  int     m_rel  = 0;

  range_counter #(.DATA_WIDTH(W), .WRAP_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .up          (up),
    .mode        (mode),
    .step        (step),
    .lower_bound (lower_bound),
    .upper_bound (upper_bound),
    .load        (load),
    .load_value  (load_value),
    .out         (out),
    .tc          (tc),
    .wrap_cnt    (wrap_cnt),
    .done        (done),
    .bound_err   (bound_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic wrap_event();
    m_tc = 1;
    if (m_wrap < WMAX) m_wrap++;
  endtask

  // Reference behaviour for one rising edge once reset has been released.
  task automatic model_edge();
    longint lo, hi, st, nv, tgt, opp;
    int md;
    lo  = longint'(lower_bound);
    hi  = longint'(upper_bound);
    st  = (step == 0) ? 1 : longint'(step);
    md  = (mode == SAT) ? 1 : (mode == ONESHOT) ? 2 : 0;
    tgt = up ? hi : lo;
    opp = up ? lo : hi;
    m_tc = 0;
    if (m_init) begin
      m_out  = up ? lo : hi;
      m_init = 0;
    end else if (lo > hi) begin
      m_tc = 0;
    end else if (load) begin
      m_out  = (load_value < lower_bound) ? lo :
               (load_value > upper_bound) ? hi : longint'(load_value);
      m_done = 0;
    end else if (en && !m_done) begin
      if (m_out < lo || m_out > hi) begin
        m_out = opp;
        if (md == 0) wrap_event();
      end else begin
        nv = up ? m_out + st : m_out - st;
        if (up ? (nv <= hi) : (nv >= lo)) begin
          if (md == 1 && nv == tgt && m_out != tgt) m_tc = 1;
          m_out = nv;
        end else if (md == 0) begin
          m_out = opp;
          wrap_event();
        end else if (md == 1) begin
          m_tc  = (m_out != tgt);
          m_out = tgt;
        end else begin
          m_out  = tgt;
          m_tc   = 1;
          m_done = 1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = 0; m_tc = 0; m_wrap = 0; m_done = 0; m_init = 1; m_rel = 0;
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      model_edge();
    end
  end

  always @(negedge clk) begin
    check("cmp_out",       longint'(out),       m_out);
    check("cmp_tc",        longint'(tc),        longint'(m_tc));
    check("cmp_wrap_cnt",  longint'(wrap_cnt),  m_wrap);
    check("cmp_done",      longint'(done),      longint'(m_done));
    check("cmp_bound_err", longint'(bound_err), longint'(lower_bound > upper_bound));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_out[5] = '{5, 4, 3, 3, 3};
  int exp_tc[5]  = '{0, 0, 1, 0, 0};

  initial begin
    rst = 1'b1; en = 0; up = 1; load = 0; mode = WRAP;
    step = 1; lower_bound = 3; upper_bound = 10; load_value = 0;
    #1 rst = 1'b0;
    #1;
    check("reset_out", longint'(out), 0);
    check("reset_tc", longint'(tc), 0);
    check("reset_done", longint'(done), 0);
    check("reset_wrap", longint'(wrap_cnt), 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc(3);
    check("init_out", longint'(out), 3);

    // Wrap mode, counting up through two full ranges.
    en = 1;
    cyc(16);
    check("wrap_out", longint'(out), 3);
    check("wrap_cnt2", longint'(wrap_cnt), 2);
    check("wrap_tc", longint'(tc), 1);
    en = 0;

    // Saturating count down from 6.
    mode = SAT; up = 0; load = 1; load_value = 6;
    cyc(1);
    check("sat_load", longint'(out), 6);
    load = 0; en = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("sat_out", longint'(out), exp_out[i]);
      check("sat_tc", longint'(tc), exp_tc[i]);
    end
    en = 0;

    // One-shot count up by 4.
    mode = ONESHOT; up = 1; step = 4; load = 1; load_value = 3;
    cyc(1);
    check("os_load", longint'(out), 3);
    load = 0; en = 1;
    cyc(1);
    check("os_out7", longint'(out), 7);
    cyc(1);
    check("os_out10", longint'(out), 10);
    check("os_done", longint'(done), 1);
    check("os_tc", longint'(tc), 1);
    cyc(2);
    check("os_hold", longint'(out), 10);
    load = 1; load_value = 20;
    cyc(1);
    check("os_reload", longint'(out), 10);
    check("os_undone", longint'(done), 0);
    load = 0; en = 0;

    // Asynchronous reset in the middle of a count.
    mode = WRAP; step = 1; load = 1; load_value = 6;
    cyc(1);
    load = 0; en = 1;
    cyc(1);
    check("ar_out7", longint'(out), 7);
    #2 rst = 1'b0;
    #1;
    check("ar_immediate", longint'(out), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(2);
    check("ar_sync_hold", longint'(out), 0);
    cyc(1);
    check("ar_reinit", longint'(out), 3);

    // Swapped bounds freeze the count.
    cyc(2);
    check("be_pre", longint'(out), 5);
    lower_bound = 10; upper_bound = 3;
    #1;
    check("be_flag", longint'(bound_err), 1);
    cyc(3);
    check("be_hold", longint'(out), 5);
    lower_bound = 3; upper_bound = 10;
    cyc(1);
    check("be_resume", longint'(out), 6);
    en = 0;

    // Full-width upper bound: no carry wrap.
    upper_bound = 32'hFFFF_FFFF; step = 2; load = 1; load_value = 32'hFFFF_FFFE;
    cyc(1);
    check("fw_load", longint'(out), 64'hFFFF_FFFE);
    load = 0; en = 1;
    cyc(1);
    check("fw_out", longint'(out), 3);
    check("fw_tc", longint'(tc), 1);
    check("fw_wrap", longint'(wrap_cnt), 1);
    en = 0; upper_bound = 10;

    // Down-count wrap with a coarse step.
    up = 0; step = 3; load = 1; load_value = 4;
    cyc(1);
    load = 0; en = 1;
    cyc(1);
    check("dn_wrap", longint'(out), 10);
    cyc(1);
    check("dn_next", longint'(out), 7);

    // Degenerate range, step 0, mode encoding 3, wrap counter saturation.
    lower_bound = 5; upper_bound = 5; step = 0; mode = mode_t'(2'd3);
    cyc(300);
    check("eq_out", longint'(out), 5);
    check("eq_tc", longint'(tc), 1);
    check("eq_wrap_sat", longint'(wrap_cnt), 255);
    en = 0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
